// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, wait limit and arbiter state encoding for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ARB_XLEN     = 32;
  localparam int ARB_PC_WIDTH = 32;
  localparam int MEM_WAIT_MAX = 15;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_IF_WAIT  = 3'd1,
    ARB_MEM_WAIT = 3'd2,
    ARB_MEM_HOLD = 3'd3,
    ARB_IF_DRAIN = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_timer.sv
// Bus wait timer: cleared on issue, counts unacked request cycles, saturates at MAX_WAIT-1.
// Latency: expired is combinational on the last allowed cycle; no backpressure.
module bus_wait_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MEM_WAIT_MAX
) (
  input  logic clk_i,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  assign expired = cnt_en & (count == LAST);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (cnt_en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between fetch and load/store, data first; results one cycle after ack.
// Backpressure: data results held in MEM_HOLD until mem_adv_i; fetch results are single-cycle pulses.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN     = ARB_XLEN,
  parameter int PC_WIDTH = ARB_PC_WIDTH,
  parameter int MAX_WAIT = MEM_WAIT_MAX
) (
  input  logic                clk_i,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [PC_WIDTH-1:0] if_addr_i,
  input  logic                flush_i,
  output logic                if_ready_o,
  output logic [XLEN-1:0]     if_rdata_o,
  output logic                if_err_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [3:0]          mem_wstrb_i,
  input  logic [PC_WIDTH-1:0] mem_addr_i,
  input  logic [XLEN-1:0]     mem_wdata_i,
  input  logic                mem_adv_i,
  output logic                memory_ready_o,
  output logic [XLEN-1:0]     mem_rdata_o,
  output logic                mem_err_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [3:0]          bus_wstrb_o,
  output logic [PC_WIDTH-1:0] bus_addr_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [XLEN-1:0]     bus_rdata_i
);

  arb_state_e state, state_nxt;
  logic       issue_mem, issue_if;
  logic       expired, done, if_fin;

  bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk_i   (clk_i),
    .rst     (rst),
    .clr     (issue_mem | issue_if),
    .cnt_en  (bus_req_o & ~bus_ack_i),
    .expired (expired)
  );

  // A timeout completes the access exactly like an ack, just without data.
  assign done   = (bus_req_o & bus_ack_i) | expired;
  assign if_fin = (state == ARB_IF_WAIT) & done & ~flush_i;

  assign memory_ready_o = (state == ARB_MEM_HOLD) | (~mem_req_i & (state != ARB_MEM_WAIT));

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_mem = 1'b0;
    issue_if  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (mem_req_i) begin
          issue_mem = 1'b1;
          state_nxt = ARB_MEM_WAIT;
        end else if (if_req_i && !flush_i) begin
          issue_if  = 1'b1;
          state_nxt = ARB_IF_WAIT;
        end
      end
      ARB_IF_WAIT: begin
        if (done)         state_nxt = ARB_IDLE;
        else if (flush_i) state_nxt = ARB_IF_DRAIN;
      end
      ARB_MEM_WAIT: if (done)      state_nxt = ARB_MEM_HOLD;
      ARB_MEM_HOLD: if (mem_adv_i) state_nxt = ARB_IDLE;
      ARB_IF_DRAIN: if (done)      state_nxt = ARB_IDLE;
      default:                     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_wstrb_o <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_ready_o  <= 1'b0;
      if_err_o    <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
    end else begin
      if_ready_o <= 1'b0;
      if_err_o   <= 1'b0;

      if (issue_mem) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_wstrb_o <= mem_wstrb_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
      end else if (issue_if) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_wstrb_o <= '0;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
      end else if (done) begin
        bus_req_o <= 1'b0;
      end

      if ((state == ARB_MEM_WAIT) && done) begin
        mem_rdata_o <= (bus_ack_i && !bus_we_o) ? bus_rdata_i : '0;
        mem_err_o   <= ~bus_ack_i;
      end else if ((state == ARB_MEM_HOLD) && mem_adv_i) begin
        mem_err_o <= 1'b0;
      end

      if (if_fin) begin
        if_ready_o <= 1'b1;
        if_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
        if_err_o   <= ~bus_ack_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction table, directed corner sequences and a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int MAX_WAIT = 15;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_wstrb_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_adv_i = 1'b0;
  logic        memory_ready_o;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(.XLEN(32), .PC_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
    .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_adv_i(mem_adv_i),
    .memory_ready_o(memory_ready_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 load, 1 store, 2 fetch, 3 fetch flushed at bus cycle flush_cyc.
  // dly: ack arrives in the dly-th cycle of bus_req_o (never if dly > MAX_WAIT).
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;
    logic [31:0] rdat;
    int          flush_cyc;
    int          hold;
    int          exp_cyc;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what the requester should receive.
  function automatic logic [31:0] ref_rdata(input int kind, input int dly, input logic [31:0] rdat);
    if (dly > MAX_WAIT) return 32'h0;
    if (kind == 1) return 32'h0;
    return rdat;
  endfunction

  function automatic int ref_cycles(input int dly);
    return (dly <= MAX_WAIT) ? dly : MAX_WAIT;
  endfunction

  task automatic run_txn(input vec_t v);
    int  i;
    bit  done;
    if (v.kind <= 1) begin
      mem_req_i   = 1'b1;
      mem_we_i    = (v.kind == 1);
      mem_wstrb_i = v.wstrb;
      mem_addr_i  = v.addr;
      mem_wdata_i = v.wdata;
    end else begin
      if_req_i  = 1'b1;
      if_addr_i = v.addr;
    end
    step();
    if_req_i = 1'b0;
    chk("issue_req", 64'(bus_req_o), 64'(1));
    chk("bus_we", 64'(bus_we_o), 64'(v.kind == 1));
    chk("bus_wstrb", 64'(bus_wstrb_o), (v.kind <= 1) ? 64'(v.wstrb) : 64'(0));
    if (v.kind <= 1) chk("bus_wdata", 64'(bus_wdata_o), 64'(v.wdata));
    i = 0;
    done = 1'b0;
    while (!done && i < 40) begin
      i++;
      chk("bus_addr_stable", 64'(bus_addr_o), 64'(v.addr));
      chk("if_ready_quiet", 64'(if_ready_o), 64'(0));
      chk("mem_ready_busy", 64'(memory_ready_o), 64'(v.kind > 1));
      bus_ack_i   = (i == v.dly);
      bus_rdata_i = (i == v.dly) ? v.rdat : $urandom;
      flush_i     = (v.kind == 3) && (i == v.flush_cyc);
      step();
      bus_ack_i = 1'b0;
      flush_i   = 1'b0;
      if (!bus_req_o) done = 1'b1;
    end
    chk("bus_cycles", 64'(i), 64'(v.exp_cyc));
    if (v.kind <= 1) begin
      for (int h = 0; h <= v.hold; h++) begin
        chk("hold_ready", 64'(memory_ready_o), 64'(1));
        chk("hold_rdata", 64'(mem_rdata_o), 64'(v.exp_rd));
        chk("hold_err", 64'(mem_err_o), 64'(v.exp_err));
        chk("hold_bus_idle", 64'(bus_req_o), 64'(0));
        bus_ack_i   = 1'b1;
        bus_rdata_i = $urandom;
        if (h == v.hold) begin
          mem_adv_i = 1'b1;
          mem_req_i = 1'b0;
        end
        step();
        bus_ack_i = 1'b0;
      end
      mem_adv_i = 1'b0;
      chk("adv_ready", 64'(memory_ready_o), 64'(1));
      chk("adv_err_clr", 64'(mem_err_o), 64'(0));
      chk("adv_rdata_kept", 64'(mem_rdata_o), 64'(v.exp_rd));
    end else begin
      chk("if_ready", 64'(if_ready_o), 64'(v.kind == 2));
      if (v.kind == 2) begin
        chk("if_rdata", 64'(if_rdata_o), 64'(v.exp_rd));
        chk("if_err", 64'(if_err_o), 64'(v.exp_err));
      end
    end
  endtask

  initial begin
    vec_t v;

    tbl[0] = '{0, 32'h100, 32'h0,        4'h0, 3,  32'hDEADBEEF, 0, 4, 3,  32'hDEADBEEF, 1'b0};
    tbl[1] = '{2, 32'h200, 32'h0,        4'h0, 1,  32'h00000013, 0, 0, 1,  32'h00000013, 1'b0};
    tbl[2] = '{1, 32'h300, 32'hCAFEF00D, 4'hF, 2,  32'h12345678, 0, 1, 2,  32'h0,        1'b0};
    tbl[3] = '{0, 32'h104, 32'h0,        4'h0, 16, 32'h5555AAAA, 0, 2, 15, 32'h0,        1'b1};
    tbl[4] = '{2, 32'h204, 32'h0,        4'h0, 15, 32'h0BADC0DE, 0, 0, 15, 32'h0BADC0DE, 1'b0};
    tbl[5] = '{2, 32'h208, 32'h0,        4'h0, 20, 32'h11111111, 0, 0, 15, 32'h0,        1'b1};
    tbl[6] = '{3, 32'h20C, 32'h0,        4'h0, 5,  32'h22222222, 2, 0, 5,  32'h0,        1'b0};
    tbl[7] = '{3, 32'h210, 32'h0,        4'h0, 3,  32'h33333333, 3, 0, 3,  32'h0,        1'b0};
    tbl[8] = '{3, 32'h214, 32'h0,        4'h0, 30, 32'h44444444, 1, 0, 15, 32'h0,        1'b0};
    tbl[9] = '{1, 32'h308, 32'h0000BEEF, 4'h3, 16, 32'h0,        0, 0, 15, 32'h0,        1'b1};

    // Reset state
    step();
    step();
    chk("rst_bus_req", 64'(bus_req_o), 64'(0));
    chk("rst_bus_we", 64'(bus_we_o), 64'(0));
    chk("rst_bus_wstrb", 64'(bus_wstrb_o), 64'(0));
    chk("rst_bus_addr", 64'(bus_addr_o), 64'(0));
    chk("rst_bus_wdata", 64'(bus_wdata_o), 64'(0));
    chk("rst_if_ready", 64'(if_ready_o), 64'(0));
    chk("rst_if_err", 64'(if_err_o), 64'(0));
    chk("rst_if_rdata", 64'(if_rdata_o), 64'(0));
    chk("rst_mem_err", 64'(mem_err_o), 64'(0));
    chk("rst_mem_rdata", 64'(mem_rdata_o), 64'(0));
    chk("rst_mem_ready_noreq", 64'(memory_ready_o), 64'(1));
    mem_req_i = 1'b1;
    #1;
    chk("rst_mem_ready_req", 64'(memory_ready_o), 64'(0));
    mem_req_i = 1'b0;
    step();
    rst = 1'b0;
    step();

    foreach (tbl[k]) run_txn(tbl[k]);

    // Simultaneous store and fetch: store goes first, fetch follows MEM_HOLD exit.
    if_req_i    = 1'b1;
    if_addr_i   = 32'h200;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_wstrb_i = 4'hF;
    mem_addr_i  = 32'h300;
    mem_wdata_i = 32'hA5A5A5A5;
    step();
    chk("prio_req", 64'(bus_req_o), 64'(1));
    chk("prio_we", 64'(bus_we_o), 64'(1));
    chk("prio_addr", 64'(bus_addr_o), 64'(32'h300));
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    chk("prio_hold_ready", 64'(memory_ready_o), 64'(1));
    chk("prio_hold_idle", 64'(bus_req_o), 64'(0));
    step();
    chk("prio_no_fetch_in_hold", 64'(bus_req_o), 64'(0));
    mem_adv_i = 1'b1;
    mem_req_i = 1'b0;
    step();
    mem_adv_i = 1'b0;
    chk("prio_exit_idle", 64'(bus_req_o), 64'(0));
    step();
    if_req_i = 1'b0;
    chk("prio_fetch_issue", 64'(bus_req_o), 64'(1));
    chk("prio_fetch_addr", 64'(bus_addr_o), 64'(32'h200));
    chk("prio_fetch_we", 64'(bus_we_o), 64'(0));
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h00100073;
    step();
    bus_ack_i = 1'b0;
    chk("prio_fetch_ready", 64'(if_ready_o), 64'(1));
    chk("prio_fetch_rdata", 64'(if_rdata_o), 64'(32'h00100073));
    step();
    chk("prio_fetch_pulse", 64'(if_ready_o), 64'(0));

    // Reset in the middle of a data access.
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h400;
    step();
    step();
    chk("mid_busy", 64'(bus_req_o), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_req_drop", 64'(bus_req_o), 64'(0));
    chk("mid_rst_mem_ready", 64'(memory_ready_o), 64'(0));
    step();
    rst         = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hBAD0BAD0;
    step();
    bus_ack_i = 1'b0;
    chk("late_ack_reissue", 64'(bus_req_o), 64'(1));
    chk("late_ack_ready", 64'(memory_ready_o), 64'(0));
    chk("late_ack_rdata", 64'(mem_rdata_o), 64'(0));
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h600DF00D;
    step();
    bus_ack_i = 1'b0;
    chk("post_rst_ready", 64'(memory_ready_o), 64'(1));
    chk("post_rst_rdata", 64'(mem_rdata_o), 64'(32'h600DF00D));
    chk("post_rst_err", 64'(mem_err_o), 64'(0));
    mem_adv_i = 1'b1;
    mem_req_i = 1'b0;
    step();
    mem_adv_i = 1'b0;

    // Randomized transactions against the reference model.
    for (int r = 0; r < 40; r++) begin
      v.kind      = int'($urandom_range(0, 3));
      v.addr      = $urandom;
      v.wdata     = $urandom;
      v.wstrb     = 4'($urandom_range(0, 15));
      v.dly       = int'($urandom_range(1, 18));
      v.rdat      = $urandom;
      v.hold      = int'($urandom_range(0, 3));
      v.exp_cyc   = ref_cycles(v.dly);
      v.flush_cyc = int'($urandom_range(1, v.exp_cyc));
      v.exp_rd    = ref_rdata(v.kind, v.dly, v.rdat);
      v.exp_err   = (v.dly > MAX_WAIT);
      run_txn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between instruction fetch and the memory stage's load/store port. It sequences each bus transaction with a small FSM and gives data accesses priority over fetch. It generates `memory_ready_o`, which drives the memory stage register's `memory_ready_i`, and holds load results until the pipeline advances. Flushed fetches are drained, and a wait timer turns a stuck bus access into an error completion.

## Interface
- `XLEN`, 32 (`` `XLEN ``): data width.
- `PC_WIDTH`, 32 (`` `PC_WIDTH ``): address width.
- `MAX_WAIT`, 15: the maximum number of cycles `bus_req_o` stays high without `bus_ack_i` before a timeout completion.

One clock; reset is asynchronous and active-high.
- `clk_i` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `if_req_i` in 1: fetch request, level.
- `if_addr_i` in PC_WIDTH: fetch address.
- `flush_i` in 1: cancels the current or pending fetch (mispredict redirect).
- `if_ready_o` out 1: one-cycle pulse; `if_rdata_o` is valid.
- `if_rdata_o` out XLEN: fetched instruction word.
- `if_err_o` out 1: pulses with `if_ready_o` on timeout.
- `mem_req_i` in 1: data request, held until completion.
- `mem_we_i` in 1: 1 = store.
- `mem_wstrb_i` in 4: byte strobes.
- `mem_addr_i` in PC_WIDTH: data address.
- `mem_wdata_i` in XLEN: store data.
- `mem_adv_i` in 1: memory stage captured the result (`memory_ready & write_back_allow_in`).
- `memory_ready_o` out 1: data result available, or no data request.
- `mem_rdata_o` out XLEN: load data, held in MEM_HOLD.
- `mem_err_o` out 1: timeout flag, held in MEM_HOLD.
- `bus_req_o` out 1: registered bus request.
- `bus_we_o` out 1: bus write enable.
- `bus_wstrb_o` out 4: bus byte strobes.
- `bus_addr_o` out PC_WIDTH: bus address.
- `bus_wdata_o` out XLEN: bus write data.
- `bus_ack_i` in 1: bus completion, one cycle.
- `bus_rdata_i` in XLEN: bus read data, valid with `bus_ack_i`.

## Operation
- States:
  - IDLE: no bus transaction.
  - IF_WAIT: fetch transaction on the bus.
  - MEM_WAIT: data transaction on the bus.
  - MEM_HOLD: data result held for the memory stage.
  - IF_DRAIN: flushed fetch still on the bus; its response is discarded.
- IDLE, grant decision (fixed priority, data first):
  - `mem_req_i` → MEM_WAIT; latch addr/we/wstrb/wdata onto the bus outputs and set `bus_req_o`.
  - else `if_req_i & ~flush_i` → IF_WAIT; drive `bus_we_o=0` and `bus_wstrb_o=0`.
  - A `bus_ack_i` seen in IDLE or MEM_HOLD is ignored.
- Bus outputs stay stable while `bus_req_o=1`.
- MEM_WAIT completion (`bus_ack_i`, or timer expiry):
  - Clear `bus_req_o`.
  - Capture `mem_rdata_o` (`bus_rdata_i` on ack, 0 on timeout, 0 for stores).
  - Set `mem_err_o` on timeout only.
  - Go to MEM_HOLD.
- MEM_HOLD: outputs held. `mem_adv_i=1` → IDLE, which clears `mem_err_o`. `mem_rdata_o` keeps its value.
- IF_WAIT completion:
  - Clear `bus_req_o`.
  - Next cycle: `if_ready_o=1` with `if_rdata_o`, and `if_err_o` on timeout.
  - Go to IDLE.
  - If `flush_i` is high in the same cycle as the completion, `if_ready_o` is suppressed.
- IF_WAIT with `flush_i` and no completion → IF_DRAIN. IF_DRAIN returns to IDLE on ack or timeout, with no `if_ready_o`.
- `memory_ready_o` (combinational) = (state==MEM_HOLD) | (~`mem_req_i` & state!=MEM_WAIT).
- Wait timer:
  - Clears when a transaction is issued.
  - Increments each cycle `bus_req_o=1` & ~`bus_ack_i`.
  - Expiry when count==MAX_WAIT-1 with no ack. The completion is then forced and the count saturates.

## Timing
- Reset values:
  - state IDLE, `bus_req_o=0`.
  - All bus outputs 0.
  - `if_ready_o=0`, `if_err_o=0`, `mem_err_o=0`.
  - `if_rdata_o=0`, `mem_rdata_o=0`, timer 0.
  - `memory_ready_o` = ~`mem_req_i`.
- Mid-transaction reset: `bus_req_o` drops immediately (asynchronous). A late ack after reset is ignored.
- Request seen at edge t → `bus_req_o` high from t+1. `bus_ack_i` is legal in the first cycle `bus_req_o` is high.
- Ack at cycle t+k:
  - `bus_req_o` low at t+k+1.
  - `if_ready_o`, or `memory_ready_o`/`mem_rdata_o`, valid at t+k+1.
- Minimum request→result latency is 2 cycles.
- Back-to-back: after fetch completion, IDLE at t+k+1, so the next issue is at t+k+2.
- Timeout: at most MAX_WAIT cycles of `bus_req_o` high, then completion behaves as an ack.
- Simultaneous `if_req_i` and `mem_req_i` in IDLE: data wins. Fetch waits; no starvation guarantee is provided.

## Structure
- `define.v` supplies `` `XLEN `` and `` `PC_WIDTH ``, and gains `` `MEM_WAIT_MAX `` and the 3-bit state encodings `` `ARB_IDLE ``, `` `ARB_IF_WAIT ``, `` `ARB_MEM_WAIT ``, `` `ARB_MEM_HOLD ``, `` `ARB_IF_DRAIN ``.
- One sub-module: `bus_wait_timer` (clear, count, saturating expiry pulse). The FSM, bus output registers and result registers stay in the top module.

## Test plan
- Load only: `mem_req_i=1`, addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF → `memory_ready_o` and `mem_rdata_o=0xDEADBEEF` from the cycle after ack. Hold `mem_adv_i=0` for 4 cycles → values stay held. `mem_adv_i=1` → IDLE, and `memory_ready_o` follows `mem_req_i`.
- Simultaneous fetch 0x200 and store 0x300 (wstrb 0xF) → the first bus transaction is the store (`bus_we_o=1`). The fetch issues 1 cycle after MEM_HOLD exits.
- Fetch with ack in the first cycle → `if_ready_o` pulses exactly once, 2 cycles after `if_req_i` was sampled.
- Fetch, `flush_i` 1 cycle after issue, ack 4 cycles later → no `if_ready_o`. IDLE after the ack, and the new fetch issues the next cycle.
- No ack with MAX_WAIT=15 → `bus_req_o` high for exactly 15 cycles, then `mem_err_o=1`, `mem_rdata_o=0`. A later stray ack is ignored.
- Assert `rst` while in MEM_WAIT → `bus_req_o=0` in the same cycle. A post-reset ack is ignored. With `mem_req_i=1`, `memory_ready_o=0` until a new transaction completes.
